// File: rtl/ram_fifo_ctrl.sv
// Circular FIFO controller over an external synchronous RAM: UART bytes are written in,
// and one debounced push-button press pops the oldest byte onto the 7-segment display.
module ram_fifo_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DB_CYC = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  input  logic              i_push_sw,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [7:0]        o_wdata,
  output logic              o_wen,
  output logic [ADDR_W-1:0] o_raddr,
  output logic              o_ren,
  input  logic [7:0]        i_rdata,
  output logic [7:0]        o_fnd_data,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int DB_W  = $clog2(DB_CYC + 1);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYC);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYC - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD, CAP} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [1:0]        r_sync;
  logic [DB_W-1:0]   r_dbCnt;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic [7:0]        r_fnd;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_req;
  logic              w_full;
  logic              w_empty;
  logic              w_wen;
  logic              w_ren;
  logic              w_rdAdv;
  logic              w_underSet;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_wen   = i_rx_done & ~w_full;
  // The request fires on the edge where the counter would step onto DB_CYC, so a saturated count never re-fires.
  assign w_req   = r_sync[1] && (r_dbCnt == DB_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_dbCnt <= '0;
    end else begin
      r_sync <= {r_sync[0], i_push_sw};
      if (!r_sync[1])
        r_dbCnt <= '0;
      else if (r_dbCnt != DB_MAX)
        r_dbCnt <= r_dbCnt + 1'b1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_ren       = 1'b0;
    w_rdAdv     = 1'b0;
    w_underSet  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (!w_empty) w_nextState = RD;
          else          w_underSet  = 1'b1;
        end
      end
      RD: begin
        w_ren       = 1'b1;
        w_rdAdv     = 1'b1;
        w_nextState = CAP;
      end
      CAP:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_fnd       <= 8'h00;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_wen)   r_wptr <= r_wptr + 1'b1;
      if (w_rdAdv) r_rptr <= r_rptr + 1'b1;
      // A simultaneous write and pop cancel out in the occupancy count.
      case ({w_wen, w_rdAdv})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_state == CAP)        r_fnd       <= i_rdata;
      if (i_rx_done && w_full)   r_overflow  <= 1'b1;
      if (w_underSet)            r_underflow <= 1'b1;
    end
  end

  assign o_waddr     = r_wptr;
  assign o_wdata     = i_rx_data;
  assign o_wen       = w_wen;
  assign o_raddr     = r_rptr;
  assign o_ren       = w_ren;
  assign o_fnd_data  = r_fnd;
  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: directed corner cases followed by random writes/presses,
// compared against a queue-based FIFO model with a scoreboard for popped bytes.
module tb_ram_fifo_ctrl;

  localparam int ADDR_W = 3;
  localparam int DB_CYC = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [7:0]        data;
    logic [ADDR_W-1:0] addr;
  } rdExp_t;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [7:0]        i_rx_data;
  logic              i_rx_done;
  logic              i_push_sw;
  logic [ADDR_W-1:0] o_waddr;
  logic [7:0]        o_wdata;
  logic              o_wen;
  logic [ADDR_W-1:0] o_raddr;
  logic              o_ren;
  logic [7:0]        i_rdata = 8'h00;
  logic [7:0]        o_fnd_data;
  logic [ADDR_W:0]   o_count;
  logic              o_full;
  logic              o_empty;
  logic              o_overflow;
  logic              o_underflow;

  logic [7:0]        ramMem [DEPTH];

  logic [7:0]        mQ [$];
  logic [ADDR_W-1:0] mWptr;
  logic [ADDR_W-1:0] mRptr;
  logic              mOvf;
  logic              mUnf;
  logic [7:0]        mFnd;
  rdExp_t            expQ [$];

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  ram_fifo_ctrl #(.ADDR_W(ADDR_W), .DB_CYC(DB_CYC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_push_sw(i_push_sw), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen),
    .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(i_rdata), .o_fnd_data(o_fnd_data),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  // Behavioural synchronous RAM: read data appears the cycle after ren.
  always @(posedge i_clk) begin
    if (o_wen) ramMem[o_waddr] <= o_wdata;
    if (o_ren) i_rdata <= ramMem[o_raddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    expQ.delete();
    mWptr = '0;
    mRptr = '0;
    mOvf  = 1'b0;
    mUnf  = 1'b0;
    mFnd  = 8'h00;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".count"},     32'(o_count),     mQ.size());
    checkOutput({tag, ".full"},      32'(o_full),      32'(mQ.size() == DEPTH));
    checkOutput({tag, ".empty"},     32'(o_empty),     32'(mQ.size() == 0));
    checkOutput({tag, ".overflow"},  32'(o_overflow),  32'(mOvf));
    checkOutput({tag, ".underflow"}, 32'(o_underflow), 32'(mUnf));
    checkOutput({tag, ".fnd"},       32'(o_fnd_data),  32'(mFnd));
    checkOutput({tag, ".waddr"},     32'(o_waddr),     32'(mWptr));
    checkOutput({tag, ".raddr"},     32'(o_raddr),     32'(mRptr));
    checkOutput({tag, ".ren"},       32'(o_ren),       0);
  endtask

  task automatic applyReset();
    i_rst = 1'b1; i_rx_done = 1'b0; i_push_sw = 1'b0; i_rx_data = 8'h00;
    repeat (2) @(posedge i_clk);
    #1;
    modelReset();
    checkState("reset");
    checkOutput("reset.wen", 32'(o_wen), 0);
    i_rst = 1'b0;
  endtask

  task automatic writeByte(input logic [7:0] d);
    bit accept;
    @(negedge i_clk);
    i_rx_data = d;
    i_rx_done = 1'b1;
    #1;
    accept = (mQ.size() < DEPTH);
    checkOutput("write.wen", 32'(o_wen), 32'(accept));
    checkOutput("write.wdata", 32'(o_wdata), 32'(d));
    @(posedge i_clk);
    #1;
    i_rx_done = 1'b0;
    if (accept) begin
      mQ.push_back(d);
      mWptr = mWptr + 1'b1;
    end else begin
      mOvf = 1'b1;
    end
    checkState("write");
  endtask

  // Press, wait for the debounced request, optionally write or reset during the RD cycle.
  task automatic pressButton(input bit withWrite, input logic [7:0] wd, input bit abortReset);
    bit accept;
    @(negedge i_clk);
    i_push_sw = 1'b1;
    repeat (DB_CYC + 2) @(posedge i_clk);
    #1;
    if (mQ.size() > 0) begin
      checkOutput("press.renOnAccept", 32'(o_ren), 1);
      if (abortReset) begin
        i_rst = 1'b1;
        i_push_sw = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        modelReset();
        checkState("abortReset");
        return;
      end
      expQ.push_back('{data: mQ[0], addr: mRptr});
      if (withWrite) begin
        i_rx_data = wd;
        i_rx_done = 1'b1;
        #1;
        accept = (mQ.size() < DEPTH);
        checkOutput("rdWrite.wen", 32'(o_wen), 32'(accept));
      end else begin
        accept = 1'b0;
      end
      @(posedge i_clk);
      #1;
      if (withWrite) begin
        i_rx_done = 1'b0;
        if (accept) begin
          mQ.push_back(wd);
          mWptr = mWptr + 1'b1;
        end else begin
          mOvf = 1'b1;
        end
      end
      mFnd  = mQ.pop_front();
      mRptr = mRptr + 1'b1;
      checkOutput("afterRd.count", 32'(o_count), mQ.size());
    end else begin
      checkOutput("press.renWhenEmpty", 32'(o_ren), 0);
      mUnf = 1'b1;
    end
    repeat (2 * DB_CYC) @(posedge i_clk);
    @(negedge i_clk);
    i_push_sw = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    checkState("press");
  endtask

  task automatic applyStimulus(input int op, input logic [7:0] d);
    case (op)
      0:       writeByte(d);
      1:       pressButton(1'b0, d, 1'b0);
      2:       pressButton(1'b1, d, 1'b0);
      default: pressButton(1'b0, d, 1'b1);
    endcase
  endtask

  // Monitor: on every ren, check raddr and then fnd_data two edges later against the scoreboard.
  logic [1:0] pend = 2'b00;
  always @(negedge i_clk) begin
    rdExp_t e;
    if (i_rst) begin
      pend = 2'b00;
    end else begin
      if (pend[1]) begin
        if (expQ.size() == 0) begin
          checkOutput("mon.scoreboardEmpty", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("mon.fndData", 32'(o_fnd_data), 32'(e.data));
        end
      end
      pend = {pend[0], 1'b0};
      if (o_ren) begin
        if (expQ.size() == 0) begin
          checkOutput("mon.unexpectedRen", 1, 0);
        end else begin
          checkOutput("mon.raddr", 32'(o_raddr), 32'(expQ[0].addr));
          pend[0] = 1'b1;
        end
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_rx_done = 1'b0; i_rx_data = 8'h00; i_push_sw = 1'b0;
    applyReset();

    applyStimulus(0, 8'hA5);

    applyReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 8'h11 + 8'(i));
    applyStimulus(0, 8'hFF);
    applyStimulus(2, 8'hEE);
    applyStimulus(1, 8'h00);
    applyStimulus(2, 8'h77);

    applyReset();
    applyStimulus(1, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      i_push_sw = 1'b1;
      repeat (DB_CYC - 1) @(negedge i_clk);
      i_push_sw = 1'b0;
      repeat (3) @(negedge i_clk);
    end
    #1;
    checkState("bounce");

    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h30 + 8'(i));
    applyStimulus(3, 8'h00);

    applyReset();
    for (int n = 0; n < 80; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6)      applyStimulus(0, 8'($urandom));
      else if (r < 8) applyStimulus(1, 8'h00);
      else            applyStimulus(2, 8'($urandom));
    end

    repeat (4) @(posedge i_clk);
    #1;
    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter: ADDR_W, 3, RAM address width; FIFO depth is 2**ADDR_W (8 entries).
REQ-002 Parameter: DB_CYC, 50000, cycles the synchronized push_sw must stay high before a press is accepted.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx_data  input  8  received UART byte, valid while rx_done is high.
REQ-006 rx_done  input  1  one-cycle byte-received pulse, synchronous to clk.
REQ-007 push_sw  input  1  raw, asynchronous, active-high read push button.
REQ-008 waddr  output  ADDR_W  RAM write address.
REQ-009 wdata  output  8  RAM write data.
REQ-010 wen  output  1  RAM write enable.
REQ-011 raddr  output  ADDR_W  RAM read address.
REQ-012 ren  output  1  RAM read enable.
REQ-013 rdata  input  8  RAM read data; registered in the RAM and valid the cycle after ren.
REQ-014 fnd_data  output  8  last byte popped, drives the two 7-segment digits.
REQ-015 count  output  ADDR_W+1  number of stored bytes, 0..8.
REQ-016 full / empty  output  1 each  count==8 / count==0, combinational from count.
REQ-017 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-018 The block SHALL run the RAM as a circular FIFO: write pointer wptr, read pointer rptr, both ADDR_W bits, wrapping 7->0 with no extra logic.
REQ-019 Write path: wen = rx_done & ~full, waddr = wptr, wdata = rx_data, all combinational (zero latency); wptr increments on the same edge.
REQ-020 rx_done while full SHALL NOT write, SHALL leave wptr and count unchanged, and SHALL set overflow.
REQ-021 push_sw SHALL pass through a 2-flop synchronizer; a debounce counter counts while the synchronized level is high, clears when it is low, and saturates.
REQ-022 Exactly one read request pulse SHALL be generated per press, on the cycle the counter reaches DB_CYC; no further request until the level has been low for at least one cycle.
REQ-023 Read FSM states: IDLE, RD, CAP.
REQ-024 IDLE -> RD on a request with ~empty; a request while empty SHALL set underflow and stay in IDLE; a request outside IDLE SHALL be dropped silently.
REQ-025 RD (1 cycle): ren=1, raddr=rptr; rptr increments and count decrements on the exiting edge; -> CAP.
REQ-026 CAP (1 cycle): fnd_data <= rdata; -> IDLE. ren=0 in IDLE and CAP; raddr holds rptr in all states.
REQ-027 If a write and the RD decrement fall on the same edge, count SHALL stay unchanged and both pointers advance.
REQ-028 Full gating uses the current count: during RD with count==8 a same-cycle rx_done is rejected (overflow set); from CAP onward, writes to the freed slot are accepted without corrupting the byte being captured.
REQ-029 count SHALL never exceed 8 or go below 0.
REQ-030 Latency from accepted press to fnd_data update SHALL be 2 cycles (RD, CAP).

Reset
REQ-031 On rst high at a clock edge: wptr=0, rptr=0, count=0, FSM=IDLE, fnd_data=8'h00, overflow=0, underflow=0, synchronizer and debounce counter cleared. Outputs: wen=0, ren=0, empty=1, full=0.
REQ-032 rst SHALL take priority over all events; reset during RD or CAP aborts the read with no fnd_data update.
REQ-033 Sticky flags SHALL clear only on rst.

Verification
REQ-034 Reset, then rx_done with 8'hA5 -> wen=1, waddr=0, wdata=8'hA5 the same cycle; count=1, empty=0.
REQ-035 Write 8'h11..8'h18, then press -> full=1 before the press; after it, RD ren=1 raddr=0, then fnd_data=8'h11 two cycles after acceptance, count=7.
REQ-036 With full, pulse rx_done 8'hFF -> wen=0, count stays 8, overflow=1; a later pop still returns 8'h11.
REQ-037 Press while empty -> ren never asserts, underflow=1, fnd_data unchanged; a bounce shorter than DB_CYC -> no request.
REQ-038 Wrap: write 10 bytes interleaved with 6 pops -> wptr wraps to 2, pops return bytes in write order, count matches writes minus pops; a write in the RD cycle leaves count unchanged.
REQ-039 Assert rst in the RD cycle -> next cycle count=0, fnd_data=8'h00, FSM IDLE, ren=0.
